writeback_pipe: RTL and testbench

Parametrised successor to the single-cycle writeback stage. Registers the MEM/WB boundary and selects the link, ALU or load value. Adds byte/halfword/word load extraction with sign or zero extension, misalignment detection, register-0 write suppression, and stall/flush handshake. Sits between the memory stage and the register file; it also drives the writeback-to-decode forwarding path.

---
 rtl/writeback_pipe.sv | 213 +++++++++++++++++++++
 tb/tb_writeback_pipe.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_pipe.sv
// ---------------------------------------------------------------------------
// WritebackPipe -- registered MEM/WB boundary and writeback value selection.
//
// Captures the instruction leaving the memory stage. It selects one of three
// values to write back: the link value, the ALU result, or a load value
// extracted from the raw memory word. It then drives the register-file write
// port and the writeback-to-decode forwarding path. Load extraction handles
// byte/half/word (and doubleword on 64-bit builds). Memory lanes are
// big-endian, and the value is sign- or zero-extended. Misaligned loads are
// flagged and never written. Writes to register 0 are suppressed.
//
// Optional feature macro: WB_RETIRE_CNT_EN
//   When defined, adds a 32-bit retire_count output. It counts every live
//   instruction that leaves the stage when it is replaced on an unstalled edge.
//
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous, active-high; overrides stall and flush
//   in_valid     memory stage holds a valid instruction
//   in_pc        instruction PC
//   in_insn      instruction word
//   in_rdst      1 = destination is rd (insn[15:11]), 0 = rt (insn[20:16])
//   in_dmenable  instruction accesses data memory
//   in_rwe       instruction writes the register file
//   in_dmwe      memory access is a store
//   in_size      00 byte, 01 half, 10 word, 11 doubleword (64-bit only)
//   in_unsigned  zero-extend the load
//   in_addr_lo   low bits of the data address (byte lane select)
//   in_O         ALU result, or link value for JAL
//   in_D         raw data-memory read word
//   stall        hold the stage register (wins over flush)
//   flush        kill the instruction being captured
//   out_valid    stage holds a live instruction
//   rdval        register-file write data
//   rwe          register-file write enable
//   d            register-file write index
//   misalign     the held load was misaligned
//   retire_pc    PC of the held instruction
//   retire_count (WB_RETIRE_CNT_EN only) retired-instruction counter
// ---------------------------------------------------------------------------
module writeback_pipe #(
    parameter int DATA_W   = 32,
    parameter int REG_W    = 5,
    parameter int LINK_REG = 31,
    parameter int LANE_W   = $clog2(DATA_W / 8)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [31:0]       in_insn,
    input  logic              in_rdst,
    input  logic              in_dmenable,
    input  logic              in_rwe,
    input  logic              in_dmwe,
    input  logic [1:0]        in_size,
    input  logic              in_unsigned,
    input  logic [LANE_W-1:0] in_addr_lo,
    input  logic [DATA_W-1:0] in_O,
    input  logic [DATA_W-1:0] in_D,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    output logic [DATA_W-1:0] rdval,
    output logic              rwe,
    output logic [REG_W-1:0]  d,
    output logic              misalign,
    output logic [DATA_W-1:0] retire_pc
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [31:0]       retire_count
`endif
);

    // Stage registers. When the stage is empty, every field is held at zero.
    // The outputs can therefore be driven straight from the flops.
    logic              valid_q;
    logic [DATA_W-1:0] rdval_q;
    logic              rwe_q;
    logic [REG_W-1:0]  d_q;
    logic              misalign_q;
    logic [DATA_W-1:0] pc_q;

    // Combinational next-state values for the captured instruction.
    logic              is_jal;
    logic              is_load;
    logic [REG_W-1:0]  dest_sel;
    logic [DATA_W-1:0] lane_shifted;
    logic [7:0]        byte_field;
    logic [15:0]       half_field;
    logic [31:0]       word_field;
    logic [DATA_W-1:0] load_val;
    logic              misalign_hit;
    logic [DATA_W-1:0] wb_val;
    logic              wr_en;

    // The opcode and the register-field bits are the only parts of the
    // instruction word this stage looks at. The remaining bits are folded
    // into a sink so their absence is visibly deliberate.
    logic unused_insn_bits;
    assign unused_insn_bits = ^{in_insn[25:21], in_insn[10:0]};

    // Destination decode. JAL always links into LINK_REG. Other instructions
    // pick rd or rt, as chosen by the decode stage.
    always_comb begin
        is_jal   = (in_insn[31:26] == 6'b000011);
        dest_sel = in_rdst ? REG_W'(in_insn[15:11]) : REG_W'(in_insn[20:16]);
        if (is_jal) begin
            dest_sel = REG_W'(LINK_REG);
        end
    end

    // Load extraction. Lane k sits at bits [DATA_W-1-8k -: 8]. A left shift
    // by 8*addr_lo brings the first addressed lane to the top of the word.
    // Each access size then reads its field from the MSB end. Misaligned
    // cases produce garbage here, but that value is discarded further down.
    always_comb begin
        lane_shifted = in_D << {in_addr_lo, 3'b000};
        byte_field   = lane_shifted[DATA_W-1 -: 8];
        half_field   = lane_shifted[DATA_W-1 -: 16];
        word_field   = lane_shifted[DATA_W-1 -: 32];
        load_val     = '0;
        case (in_size)
            2'b00: load_val = in_unsigned ? DATA_W'(byte_field)
                                          : DATA_W'($signed(byte_field));
            2'b01: load_val = in_unsigned ? DATA_W'(half_field)
                                          : DATA_W'($signed(half_field));
            2'b10: load_val = in_unsigned ? DATA_W'(word_field)
                                          : DATA_W'($signed(word_field));
            default: load_val = (DATA_W == 64) ? in_D : '0;
        endcase
    end

    // Alignment check for loads. A doubleword access does not exist on a
    // 32-bit datapath, so it is treated as misaligned and never written.
    always_comb begin
        is_load      = in_dmenable & ~in_dmwe;
        misalign_hit = 1'b0;
        case (in_size)
            2'b01:   misalign_hit = in_addr_lo[0];
            2'b10:   misalign_hit = (in_addr_lo[1:0] != 2'b00);
            2'b11:   misalign_hit = (DATA_W == 32) ? 1'b1
                                                   : (in_addr_lo != '0);
            default: misalign_hit = 1'b0;
        endcase
        misalign_hit = misalign_hit & is_load;
    end

    // Writeback value and write enable. Non-memory instructions and stores
    // pass the ALU/link value through. A misaligned load writes zero and is
    // never enabled. Register 0 is hard-wired, so it is never written.
    always_comb begin
        wb_val = is_load ? load_val : in_O;
        if (misalign_hit) begin
            wb_val = '0;
        end
        wr_en = in_rwe & ~misalign_hit & (dest_sel != '0);
    end

    // Stage register. Reset wins over everything. A stall freezes every
    // field, including valid, and so masks a simultaneous flush. A flushed
    // or invalid capture loads an all-zero bubble.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q    <= 1'b0;
            rdval_q    <= '0;
            rwe_q      <= 1'b0;
            d_q        <= '0;
            misalign_q <= 1'b0;
            pc_q       <= '0;
        end else if (!stall) begin
            if (in_valid && !flush) begin
                valid_q    <= 1'b1;
                rdval_q    <= wb_val;
                rwe_q      <= wr_en;
                d_q        <= dest_sel;
                misalign_q <= misalign_hit;
                pc_q       <= in_pc;
            end else begin
                valid_q    <= 1'b0;
                rdval_q    <= '0;
                rwe_q      <= 1'b0;
                d_q        <= '0;
                misalign_q <= 1'b0;
                pc_q       <= '0;
            end
        end
    end

`ifdef WB_RETIRE_CNT_EN
    // Retire counter. An instruction retires when it is pushed out of the
    // stage by an unstalled edge. The count wraps naturally at 32 bits.
    logic [31:0] retire_count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            retire_count_q <= '0;
        end else if (!stall && valid_q) begin
            retire_count_q <= retire_count_q + 32'd1;
        end
    end

    assign retire_count = retire_count_q;
`endif

    assign out_valid = valid_q;
    assign rdval     = rdval_q;
    assign rwe       = rwe_q;
    assign d         = d_q;
    assign misalign  = misalign_q;
    assign retire_pc = pc_q;

endmodule

// File: tb/tb_writeback_pipe.sv
// ---------------------------------------------------------------------------
// tb_writeback_pipe -- directed self-checking bench for writeback_pipe
// (32-bit default build). Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_writeback_pipe;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int LANE_W = 2;

    logic              clock;
    logic              reset;
    logic              in_valid;
    logic [DATA_W-1:0] in_pc;
    logic [31:0]       in_insn;
    logic              in_rdst;
    logic              in_dmenable;
    logic              in_rwe;
    logic              in_dmwe;
    logic [1:0]        in_size;
    logic              in_unsigned;
    logic [LANE_W-1:0] in_addr_lo;
    logic [DATA_W-1:0] in_O;
    logic [DATA_W-1:0] in_D;
    logic              stall;
    logic              flush;
    logic              out_valid;
    logic [DATA_W-1:0] rdval;
    logic              rwe;
    logic [REG_W-1:0]  d;
    logic              misalign;
    logic [DATA_W-1:0] retire_pc;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0]       retire_count;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] INSN_JAL   = 32'h0C00_0010;
    localparam logic [31:0] INSN_LOAD  = 32'h8008_0000;
    localparam logic [31:0] INSN_RD0   = 32'h0000_0020;
    localparam logic [31:0] INSN_RD5   = 32'h0000_2820;
    localparam logic [31:0] INSN_STORE = 32'hAC08_0000;

    writeback_pipe #(
        .DATA_W   (DATA_W),
        .REG_W    (REG_W),
        .LINK_REG (31)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_pc       (in_pc),
        .in_insn     (in_insn),
        .in_rdst     (in_rdst),
        .in_dmenable (in_dmenable),
        .in_rwe      (in_rwe),
        .in_dmwe     (in_dmwe),
        .in_size     (in_size),
        .in_unsigned (in_unsigned),
        .in_addr_lo  (in_addr_lo),
        .in_O        (in_O),
        .in_D        (in_D),
        .stall       (stall),
        .flush       (flush),
        .out_valid   (out_valid),
        .rdval       (rdval),
        .rwe         (rwe),
        .d           (d),
        .misalign    (misalign),
        .retire_pc   (retire_pc)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retire_count(retire_count)
`endif
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Compares one observed value against its expected constant.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one instruction onto the inputs, then advances one clock edge.
    // Outputs are sampled 1 unit after the edge.
    task automatic applyStimulus(input logic v, input logic [31:0] pc,
                                 input logic [31:0] insn, input logic rdst,
                                 input logic dmen, input logic wen,
                                 input logic dmwe, input logic [1:0] size,
                                 input logic uns, input logic [1:0] addr,
                                 input logic [31:0] o_val, input logic [31:0] d_val);
        in_valid    = v;
        in_pc       = pc;
        in_insn     = insn;
        in_rdst     = rdst;
        in_dmenable = dmen;
        in_rwe      = wen;
        in_dmwe     = dmwe;
        in_size     = size;
        in_unsigned = uns;
        in_addr_lo  = addr;
        in_O        = o_val;
        in_D        = d_val;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;

        // Reset held two edges with a valid instruction presented.
        applyStimulus(1, 32'h100, INSN_JAL, 0, 0, 1, 0, 2'b10, 0, 0, 32'h1111, 32'h0);
        applyStimulus(1, 32'h104, INSN_JAL, 0, 0, 1, 0, 2'b10, 0, 0, 32'h2222, 32'h0);
        checkOutput("reset_valid", out_valid, 0);
        checkOutput("reset_rwe", rwe, 0);
        checkOutput("reset_rdval", rdval, 0);
        checkOutput("reset_d", d, 0);
        checkOutput("reset_misalign", misalign, 0);
        checkOutput("reset_pc", retire_pc, 0);
`ifdef WB_RETIRE_CNT_EN
        checkOutput("reset_count", retire_count, 0);
`endif
        reset = 1'b0;

        // JAL links to r31.
        applyStimulus(1, 32'h0040_0004, INSN_JAL, 0, 0, 1, 0, 2'b10, 0, 0, 32'h0040_0008, 32'h0);
        checkOutput("jal_valid", out_valid, 1);
        checkOutput("jal_d", d, 31);
        checkOutput("jal_rdval", rdval, 32'h0040_0008);
        checkOutput("jal_rwe", rwe, 1);
        checkOutput("jal_pc", retire_pc, 32'h0040_0004);

        // LB signed, lane 1 of 0x12F45678.
        applyStimulus(1, 32'h200, INSN_LOAD, 0, 1, 1, 0, 2'b00, 0, 1, 32'h1001, 32'h12F4_5678);
        checkOutput("lb_rdval", rdval, 32'hFFFF_FFF4);
        checkOutput("lb_d", d, 8);
        checkOutput("lb_rwe", rwe, 1);

        // LBU, same lane.
        applyStimulus(1, 32'h204, INSN_LOAD, 0, 1, 1, 0, 2'b00, 1, 1, 32'h1001, 32'h12F4_5678);
        checkOutput("lbu_rdval", rdval, 32'h0000_00F4);

        // LH at odd address is misaligned.
        applyStimulus(1, 32'h208, INSN_LOAD, 0, 1, 1, 0, 2'b01, 0, 3, 32'h1003, 32'hFFFF_FFFF);
        checkOutput("lh_mis_flag", misalign, 1);
        checkOutput("lh_mis_rwe", rwe, 0);
        checkOutput("lh_mis_rdval", rdval, 0);
        checkOutput("lh_mis_valid", out_valid, 1);

        // Aligned LH, lanes 2..3.
        applyStimulus(1, 32'h20C, INSN_LOAD, 0, 1, 1, 0, 2'b01, 0, 2, 32'h1002, 32'h0000_8001);
        checkOutput("lh_rdval", rdval, 32'hFFFF_8001);
        checkOutput("lh_misalign", misalign, 0);
        checkOutput("lh_rwe", rwe, 1);

        // LHU, lanes 0..1.
        applyStimulus(1, 32'h210, INSN_LOAD, 0, 1, 1, 0, 2'b01, 1, 0, 32'h1000, 32'h8001_1234);
        checkOutput("lhu_rdval", rdval, 32'h0000_8001);

        // LW aligned, full word.
        applyStimulus(1, 32'h214, INSN_LOAD, 0, 1, 1, 0, 2'b10, 0, 0, 32'h1000, 32'h89AB_CDEF);
        checkOutput("lw_rdval", rdval, 32'h89AB_CDEF);

        // LW at addr_lo=2 is misaligned.
        applyStimulus(1, 32'h218, INSN_LOAD, 0, 1, 1, 0, 2'b10, 0, 2, 32'h1002, 32'h89AB_CDEF);
        checkOutput("lw_mis_flag", misalign, 1);
        checkOutput("lw_mis_rdval", rdval, 0);

        // Doubleword size on a 32-bit build is always misaligned.
        applyStimulus(1, 32'h21C, INSN_LOAD, 0, 1, 1, 0, 2'b11, 0, 0, 32'h1000, 32'h89AB_CDEF);
        checkOutput("ld32_mis_flag", misalign, 1);
        checkOutput("ld32_rwe", rwe, 0);

        // Store with rwe writes the ALU value, not memory data.
        applyStimulus(1, 32'h220, INSN_STORE, 0, 1, 1, 1, 2'b00, 0, 1, 32'h0000_0055, 32'hAAAA_AAAA);
        checkOutput("store_rdval", rdval, 32'h0000_0055);
        checkOutput("store_rwe", rwe, 1);
        checkOutput("store_misalign", misalign, 0);

        // R-type targeting r0 is never written.
        applyStimulus(1, 32'h224, INSN_RD0, 1, 0, 1, 0, 2'b10, 0, 0, 32'h0000_0077, 32'h0);
        checkOutput("rd0_rwe", rwe, 0);
        checkOutput("rd0_d", d, 0);
        checkOutput("rd0_rdval", rdval, 32'h0000_0077);

        // Three stalled cycles with new inputs presented: all outputs hold.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 32'h300, INSN_JAL, 0, 0, 1, 0, 2'b10, 0, 0, 32'hDEAD_BEEF, 32'h0);
            checkOutput("stall_rdval", rdval, 32'h0000_0077);
            checkOutput("stall_valid", out_valid, 1);
            checkOutput("stall_pc", retire_pc, 32'h224);
        end
        stall = 1'b0;

        // Flush with stall low kills the captured instruction.
        flush = 1'b1;
        applyStimulus(1, 32'h304, INSN_JAL, 0, 0, 1, 0, 2'b10, 0, 0, 32'h1234_5678, 32'h0);
        checkOutput("flush_valid", out_valid, 0);
        checkOutput("flush_rwe", rwe, 0);
        checkOutput("flush_rdval", rdval, 0);
        flush = 1'b0;

        // A live R-type to r5, then stall and flush together: stall wins.
        applyStimulus(1, 32'h308, INSN_RD5, 1, 0, 1, 0, 2'b10, 0, 0, 32'h0000_1234, 32'h0);
        checkOutput("rd5_d", d, 5);
        checkOutput("rd5_rwe", rwe, 1);
        stall = 1'b1;
        flush = 1'b1;
        applyStimulus(1, 32'h30C, INSN_JAL, 0, 0, 1, 0, 2'b10, 0, 0, 32'hCAFE_0000, 32'h0);
        checkOutput("stallflush_valid", out_valid, 1);
        checkOutput("stallflush_rdval", rdval, 32'h0000_1234);
        checkOutput("stallflush_d", d, 5);
        checkOutput("stallflush_rwe", rwe, 1);
        stall = 1'b0;
        flush = 1'b0;

`ifdef WB_RETIRE_CNT_EN
        // Counter: clear, then five valid instructions and one bubble to
        // push the last one out.
        reset = 1'b1;
        applyStimulus(0, 32'h0, INSN_RD5, 1, 0, 1, 0, 2'b10, 0, 0, 32'h0, 32'h0);
        checkOutput("cnt_reset", retire_count, 0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 32'h400 + 32'(4 * i), INSN_RD5, 1, 0, 1, 0, 2'b10, 0, 0, 32'(i), 32'h0);
        end
        checkOutput("cnt_after5", retire_count, 4);
        applyStimulus(0, 32'h0, INSN_RD5, 1, 0, 1, 0, 2'b10, 0, 0, 32'h0, 32'h0);
        checkOutput("cnt_retired5", retire_count, 5);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
